// File: rtl/ser_load_ctrl_pkg.sv
// Shared definitions for the serial word-assembly blocks.
//   state_e   : FSM encoding (IDLE=0, LOAD=1, DONE=2)
//   DEF_WIDTH : default word length in bits
//   DEF_CNT_W : default bit-index width, log2(DEF_WIDTH)
package ser_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/ser_load_ctrl_bit_counter.sv
// bit_counter: bit-index counter for the serial loader.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0, wins over en
//   en       : increment by one, wrapping modulo 2**CNT_W
//   count    : current index
//   tc       : terminal count, high while count is all ones
module bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign tc    = &count_q;

endmodule

// File: rtl/ser_load_ctrl.sv
// ser_load_ctrl: assembles one WIDTH-bit word from a serial LSB-first stream.
//   CLK, RST   : clock, asynchronous active-high reset
//   START      : begin a load (honoured in IDLE only)
//   ABORT      : drop the load / completed word (LOAD or DONE only)
//   BIT_VALID  : BIT_IN is valid this cycle
//   BIT_IN     : serial data, LSB first
//   ACK        : consumer took WORD_OUT (honoured in DONE only)
//   COUNT      : index of the next bit write (demux select)
//   WR_EN      : demux write strobe, combinational
//   WORD_OUT   : assembled word, registered
//   WORD_VALID : WORD_OUT complete (DONE state)
//   BUSY       : LOAD or DONE
module ser_load_ctrl
  import ser_load_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             BIT_VALID,
  input  logic             BIT_IN,
  input  logic             ACK,
  output logic [CNT_W-1:0] COUNT,
  output logic             WR_EN,
  output logic [WIDTH-1:0] WORD_OUT,
  output logic             WORD_VALID,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             cnt_clr, cnt_en, cnt_tc;

  bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (CLK),
    .rst   (RST),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (COUNT),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // ABORT alongside START keeps the block idle
        if (START && !ABORT) begin
          state_d = ST_LOAD;
          word_d  = '0;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          word_d  = '0;
          cnt_clr = 1'b1;
        end else if (BIT_VALID) begin
          word_d[COUNT] = BIT_IN;
          cnt_en        = 1'b1;   // wraps to 0 on the last bit
          if (cnt_tc) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          word_d  = '0;
          cnt_clr = 1'b1;
        end else if (ACK) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        word_d  = '0;
        cnt_clr = 1'b1;
      end
    endcase
    // flags registered from the next state so they line up with it
    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign WR_EN      = (state_q == ST_LOAD) && BIT_VALID;
  assign WORD_OUT   = word_q;
  assign WORD_VALID = valid_q;
  assign BUSY       = busy_q;

endmodule
